mem_stage: RTL and testbench

MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM control and data registers. It performs the data-memory access over a req/ack handshake and stalls the pipeline while the access is outstanding. It resolves branch/jump redirect and registers results into the MEM/WB boundary.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_wb_reg.sv | 52 +++++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   - default data/address width and register-index width
//   - encoding of the memory-access FSM (IDLE = 0, WAIT = 1)
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg
// MEM/WB pipeline boundary register with a bubble input.
//   clk, rst          : clock, synchronous active-high reset (clears all)
//   i_bubble          : 1 = insert bubble (RegWrite/MemtoReg cleared,
//                       data fields hold); 0 = capture all inputs
//   i_reg_write,
//   i_mem_to_reg      : control bits to capture
//   i_mem_data,
//   i_alu_result, i_rd: data fields to capture
//   o_*               : registered copies
// ---------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_bubble,
  input  logic              i_reg_write,
  input  logic              i_mem_to_reg,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [REG_W-1:0]  i_rd,
  output logic              o_reg_write,
  output logic              o_mem_to_reg,
  output logic [DATA_W-1:0] o_mem_data,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [REG_W-1:0]  o_rd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_mem_data   <= '0;
      o_alu_result <= '0;
      o_rd         <= '0;
    end else if (i_bubble) begin
      // Bubble: kill the write-back side effects, keep the data fields.
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
    end else begin
      o_reg_write  <= i_reg_write;
      o_mem_to_reg <= i_mem_to_reg;
      o_mem_data   <= i_mem_data;
      o_alu_result <= i_alu_result;
      o_rd         <= i_rd;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage pipeline. Issues the data-memory access over a
// req/ack handshake, stalls upstream while the access is outstanding,
// aborts after MAX_WAIT-1 unacknowledged wait cycles, resolves branch/jump
// redirect and registers results into MEM/WB.
//
// Handshake: dmem_req is held high (with stable addr/we/wdata, because the
// upstream registers are frozen by stall_Out) until the cycle dmem_ack=1;
// that cycle completes the access and stall_Out drops. dmem_ack is ignored
// whenever no request is being made.
//
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   Branch_In .. rd_In     : EX/MEM control and data
//   dmem_req/we/addr/wdata : memory request side
//   dmem_rdata, dmem_ack   : memory response side
//   stall_Out              : freeze PC, IF/ID, ID/EX, EX/MEM
//   pc_src_Out             : take branch/jump target
//   mem_err_Out            : one-cycle pulse on access timeout
//   RegWrite_Out .. rd_Out : MEM/WB register outputs
//   o_dbg_state            : current FSM state (mem_state_e encoding)
// ---------------------------------------------------------------------------
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Branch_In,
  input  logic              MemRead_In,
  input  logic              MemtoReg_In,
  input  logic              MemWrite_In,
  input  logic              RegWrite_In,
  input  logic              jump_In,
  input  logic              zero_In,
  input  logic [DATA_W-1:0] alu_result_In,
  input  logic [DATA_W-1:0] store_data_In,
  input  logic [REG_W-1:0]  rd_In,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_Out,
  output logic              pc_src_Out,
  output logic              mem_err_Out,
  output logic              RegWrite_Out,
  output logic              MemtoReg_Out,
  output logic [DATA_W-1:0] mem_data_Out,
  output logic [DATA_W-1:0] alu_result_Out,
  output logic [REG_W-1:0]  rd_Out,
  output logic              o_dbg_state
);

  localparam int CNT_W = $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  mem_state_e        r_state, w_next_state;
  logic [CNT_W-1:0]  r_cnt, w_next_cnt;

  logic              w_memop;
  logic              w_is_load;
  logic              w_req;
  logic              w_stall;
  logic              w_abort;
  logic              w_acked;
  logic [DATA_W-1:0] w_mem_data;

  assign w_memop   = MemRead_In | MemWrite_In;
  // Read and write together is illegal and is handled as a write.
  assign w_is_load = MemRead_In & ~MemWrite_In;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_abort      = 1'b0;
    w_acked      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_memop) begin
          w_req = 1'b1;
          if (dmem_ack) begin
            // Zero-wait memory: complete without stalling.
            w_acked = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_next_state = ST_WAIT;
            w_next_cnt   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (dmem_ack) begin
          w_req        = 1'b1;
          w_acked      = 1'b1;
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          // Timeout: drop the request and release the pipeline this cycle.
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else begin
          w_req      = 1'b1;
          w_stall    = 1'b1;
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign dmem_req    = w_req & ~rst;
  assign stall_Out   = w_stall & ~rst;
  assign mem_err_Out = w_abort & ~rst;
  assign pc_src_Out  = ((Branch_In & zero_In) | jump_In) & ~stall_Out;

  assign dmem_we     = MemWrite_In;
  assign dmem_addr   = alu_result_In;
  assign dmem_wdata  = store_data_In;
  assign o_dbg_state = r_state;

  assign w_mem_data = (w_is_load & w_acked) ? dmem_rdata : '0;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk          (clk),
    .rst          (rst),
    .i_bubble     (stall_Out),
    .i_reg_write  (RegWrite_In & ~w_abort),
    .i_mem_to_reg (MemtoReg_In),
    .i_mem_data   (w_mem_data),
    .i_alu_result (alu_result_In),
    .i_rd         (rd_In),
    .o_reg_write  (RegWrite_Out),
    .o_mem_to_reg (MemtoReg_Out),
    .o_mem_data   (mem_data_Out),
    .o_alu_result (alu_result_Out),
    .o_rd         (rd_Out)
  );

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Inputs change shortly after each rising
// edge; a single compare process on the falling edge checks every output
// against a transaction-level model, and the driver adds hand-computed
// literal checks after each directed scenario.
// ---------------------------------------------------------------------------
module tb_mem_stage;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int MAX_WAIT = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic              Branch_In, MemRead_In, MemtoReg_In, MemWrite_In;
  logic              RegWrite_In, jump_In, zero_In;
  logic [DATA_W-1:0] alu_result_In, store_data_In;
  logic [REG_W-1:0]  rd_In;
  logic              dmem_req, dmem_we;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic              dmem_ack;
  logic              stall_Out, pc_src_Out, mem_err_Out;
  logic              RegWrite_Out, MemtoReg_Out;
  logic [DATA_W-1:0] mem_data_Out, alu_result_Out;
  logic [REG_W-1:0]  rd_Out;
  logic              o_dbg_state;

  mem_stage #(
    .DATA_W   (DATA_W),
    .REG_W    (REG_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .Branch_In      (Branch_In),
    .MemRead_In     (MemRead_In),
    .MemtoReg_In    (MemtoReg_In),
    .MemWrite_In    (MemWrite_In),
    .RegWrite_In    (RegWrite_In),
    .jump_In        (jump_In),
    .zero_In        (zero_In),
    .alu_result_In  (alu_result_In),
    .store_data_In  (store_data_In),
    .rd_In          (rd_In),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_ack       (dmem_ack),
    .stall_Out      (stall_Out),
    .pc_src_Out     (pc_src_Out),
    .mem_err_Out    (mem_err_Out),
    .RegWrite_Out   (RegWrite_Out),
    .MemtoReg_Out   (MemtoReg_Out),
    .mem_data_Out   (mem_data_Out),
    .alu_result_Out (alu_result_Out),
    .rd_Out         (rd_Out),
    .o_dbg_state    (o_dbg_state)
  );

  // scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;
  int obs_stall = 0;
  int obs_err   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Model: tracks how many stall cycles the current access has used and the
  // expected MEM/WB contents after each rising edge.
  // ------------------------------------------------------------------------
  int                m_wait = 0;
  logic              m_rw = 1'b0, m_mtr = 1'b0;
  logic [DATA_W-1:0] m_data = '0, m_alu = '0;
  logic [REG_W-1:0]  m_rd = '0;
  logic              e_req, e_stall, e_err, e_pc, e_memop;
  logic [31:0]       exp_q[$];  // expected mem_data after completed loads

  always @(negedge clk) begin
    // Registered outputs reflect the previous rising edge.
    chk("RegWrite_Out", 32'(RegWrite_Out), 32'(m_rw));
    chk("MemtoReg_Out", 32'(MemtoReg_Out), 32'(m_mtr));
    chk("mem_data_Out", mem_data_Out, m_data);
    chk("alu_result_Out", alu_result_Out, m_alu);
    chk("rd_Out", 32'(rd_Out), 32'(m_rd));

    // Combinational outputs for the inputs of the current cycle.
    e_memop = MemRead_In | MemWrite_In;
    e_req = 1'b0; e_stall = 1'b0; e_err = 1'b0;
    if (!rst && e_memop) begin
      if (dmem_ack) e_req = 1'b1;
      else if (m_wait == MAX_WAIT - 1) e_err = 1'b1;
      else begin e_req = 1'b1; e_stall = 1'b1; end
    end
    e_pc = ((Branch_In & zero_In) | jump_In) & ~e_stall & ~rst;
    chk("dmem_req", 32'(dmem_req), 32'(e_req));
    chk("stall_Out", 32'(stall_Out), 32'(e_stall));
    chk("mem_err_Out", 32'(mem_err_Out), 32'(e_err));
    chk("pc_src_Out", 32'(pc_src_Out), 32'(e_pc));
    chk("dmem_we", 32'(dmem_we), 32'(MemWrite_In));
    chk("dmem_addr", dmem_addr, alu_result_In);
    chk("dmem_wdata", dmem_wdata, store_data_In);

    if (stall_Out)   obs_stall++;
    if (mem_err_Out) obs_err++;

    // Predict the next rising edge.
    if (rst) begin
      m_wait = 0; m_rw = 0; m_mtr = 0; m_data = '0; m_alu = '0; m_rd = '0;
    end else if (e_stall) begin
      m_wait++; m_rw = 0; m_mtr = 0;
    end else begin
      m_wait = 0;
      m_rw   = RegWrite_In & ~e_err;
      m_mtr  = MemtoReg_In;
      m_alu  = alu_result_In;
      m_rd   = rd_In;
      m_data = (MemRead_In && !MemWrite_In && dmem_ack) ? dmem_rdata : '0;
      if (MemRead_In && !MemWrite_In && dmem_ack) exp_q.push_back(dmem_rdata);
    end
  end

  // ------------------------------------------------------------------------
  // driver tasks
  // ------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    Branch_In = 0; MemRead_In = 0; MemtoReg_In = 0; MemWrite_In = 0;
    RegWrite_In = 0; jump_In = 0; zero_In = 0;
    alu_result_In = '0; store_data_In = '0; rd_In = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
    clear_inputs();
    MemRead_In = 1; MemtoReg_In = 1; RegWrite_In = 1;
    alu_result_In = addr; rd_In = rd;
  endtask

  // Hold the current access with ack low for k cycles, then ack with rdata.
  task automatic ack_after(input int k, input logic [31:0] rdata);
    for (int i = 0; i < k; i++) begin
      dmem_ack = 0;
      step();
    end
    dmem_ack = 1; dmem_rdata = $urandom_range(0, 1) ? rdata : rdata;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    step(); step();
    chk("reset RegWrite_Out", 32'(RegWrite_Out), 32'd0);
    chk("reset state", 32'(o_dbg_state), 32'd0);
    rst = 0;

    // R-type, no memory op
    RegWrite_In = 1; rd_In = 5'd7; alu_result_In = 32'h2A;
    #1;
    chk("rtype dmem_req", 32'(dmem_req), 32'd0);
    chk("rtype stall", 32'(stall_Out), 32'd0);
    step();
    chk("rtype RegWrite_Out", 32'(RegWrite_Out), 32'd1);
    chk("rtype rd_Out", 32'(rd_Out), 32'd7);
    chk("rtype alu_result_Out", alu_result_Out, 32'h2A);

    // Stray ack with no memory op is ignored
    clear_inputs();
    RegWrite_In = 1; rd_In = 5'd3; alu_result_In = 32'h11;
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    step();
    chk("stray ack mem_data_Out", mem_data_Out, 32'h0);

    // Load at 0x100, ack after 3 wait cycles
    set_load(32'h100, 5'd9);
    obs_stall = 0;
    ack_after(3, 32'hDEADBEEF);
    chk("load stall cycles", 32'(obs_stall), 32'd3);
    chk("load mem_data_Out", mem_data_Out, 32'hDEADBEEF);
    chk("load MemtoReg_Out", 32'(MemtoReg_Out), 32'd1);
    chk("load rd_Out", 32'(rd_Out), 32'd9);
    if (exp_q.size() == 0) chk("load queue", 32'd0, 32'd1);
    else chk("load queue", mem_data_Out, exp_q.pop_front());

    // Store, zero-wait
    clear_inputs();
    MemWrite_In = 1; alu_result_In = 32'h40; store_data_In = 32'h55; dmem_ack = 1;
    #1;
    chk("store dmem_we", 32'(dmem_we), 32'd1);
    chk("store stall", 32'(stall_Out), 32'd0);
    chk("store dmem_wdata", dmem_wdata, 32'h55);
    step();
    chk("store RegWrite_Out", 32'(RegWrite_Out), 32'd0);

    // Zero-wait load
    set_load(32'h200, 5'd4);
    dmem_ack = 1; dmem_rdata = 32'h0BADC0DE;
    step();
    chk("zw load mem_data_Out", mem_data_Out, 32'h0BADC0DE);
    void'(exp_q.pop_front());

    // Read+write together is a write: no load data captured
    clear_inputs();
    MemRead_In = 1; MemWrite_In = 1; dmem_ack = 1; dmem_rdata = 32'h77777777;
    #1;
    chk("rw dmem_we", 32'(dmem_we), 32'd1);
    step();
    chk("rw mem_data_Out", mem_data_Out, 32'h0);

    // Branch / jump redirect
    clear_inputs();
    Branch_In = 1; zero_In = 1;
    #1; chk("branch taken", 32'(pc_src_Out), 32'd1);
    step();
    zero_In = 0;
    #1; chk("branch not taken", 32'(pc_src_Out), 32'd0);
    step();
    Branch_In = 0; jump_In = 1;
    #1; chk("jump", 32'(pc_src_Out), 32'd1);
    step();

    // Load with no ack: timeout
    set_load(32'h300, 5'd12);
    obs_stall = 0; obs_err = 0;
    for (int i = 0; i < MAX_WAIT - 1; i++) step();
    #1;
    chk("timeout mem_err_Out", 32'(mem_err_Out), 32'd1);
    chk("timeout dmem_req", 32'(dmem_req), 32'd0);
    chk("timeout stall", 32'(stall_Out), 32'd0);
    step();
    clear_inputs();
    chk("timeout stall cycles", 32'(obs_stall), 32'd15);
    chk("timeout err pulses", 32'(obs_err), 32'd1);
    chk("timeout RegWrite_Out", 32'(RegWrite_Out), 32'd0);
    chk("timeout mem_data_Out", mem_data_Out, 32'h0);
    chk("timeout state", 32'(o_dbg_state), 32'd0);
    step();
    chk("timeout single pulse", 32'(obs_err), 32'd1);

    // Reset in the middle of a wait
    set_load(32'h400, 5'd21);
    for (int i = 0; i < 4; i++) step();
    chk("pre-reset state", 32'(o_dbg_state), 32'd1);
    rst = 1;
    #1;
    chk("in-reset dmem_req", 32'(dmem_req), 32'd0);
    step();
    chk("post-reset state", 32'(o_dbg_state), 32'd0);
    chk("post-reset mem_err", 32'(mem_err_Out), 32'd0);
    chk("post-reset RegWrite_Out", 32'(RegWrite_Out), 32'd0);
    chk("post-reset alu_result_Out", alu_result_Out, 32'h0);
    rst = 0;
    obs_stall = 0;
    ack_after(2, 32'h12345678);
    chk("after-reset load stalls", 32'(obs_stall), 32'd2);
    chk("after-reset load data", mem_data_Out, 32'h12345678);
    chk("after-reset load rd", 32'(rd_Out), 32'd21);
    void'(exp_q.pop_front());
    clear_inputs();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
